// File: rtl/m31_pkg.sv
// Shared M31 field definitions: modulus, FSM state type and the canon/dbl/addm
// primitives used by both the multiplier and the divider's final reduction.
package m31_pkg;

    localparam int unsigned NB = 31;
    localparam logic [NB-1:0] P = 31'h7FFFFFFF;

    typedef enum logic {IDLE, RUN} state_t;

    function automatic logic [NB-1:0] canon(input logic [NB-1:0] x);
        return (x == P) ? '0 : x;
    endfunction

    // Rotate-left doubles modulo p because 2^NB == 1 (mod p).
    function automatic logic [NB-1:0] dbl(input logic [NB-1:0] x);
        return {x[NB-2:0], x[NB-1]};
    endfunction

    function automatic logic [NB-1:0] addm(input logic [NB-1:0] x, input logic [NB-1:0] y);
        logic [NB:0]   s;
        logic [NB-1:0] t;
        s = {1'b0, x} + {1'b0, y};
        t = s[NB-1:0] + {{(NB-1){1'b0}}, s[NB]};
        return (t == P) ? '0 : t;
    endfunction

endpackage

// File: rtl/m31_addm.sv
// Combinational modular adder over GF(2^31-1); inputs must be canonical.
module m31_addm
    import m31_pkg::*;
(
    input  logic [NB-1:0] i_x,
    input  logic [NB-1:0] i_y,
    output logic [NB-1:0] o_sum
);

    assign o_sum = addm(i_x, i_y);

endmodule

// File: rtl/mod_mul_m31.sv
// Sequential M31 modular multiplier: radix-2 MSB-first double-and-add,
// one multiplier bit per cycle, fixed 31-cycle latency.
module mod_mul_m31 #(
    parameter int unsigned NB = 31
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          opselect,
    input  logic [NB-1:0] a,
    input  logic [NB-1:0] b,
    output logic [NB-1:0] _mul,
    output logic          _rdy,
    output logic          _done
);
    import m31_pkg::*;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [4:0]    r_cnt;
    logic [NB-1:0] r_ra;
    logic [NB-1:0] r_rb;
    logic [NB-1:0] r_acc;
    logic [NB-1:0] w_acc_dbl;
    logic [NB-1:0] w_addend;
    logic [NB-1:0] w_acc_nxt;
    logic          w_start;
    logic          w_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (opselect) begin
                    w_start     = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (r_cnt == 5'd0) begin
                    w_last      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_acc_dbl = dbl(r_acc);
    assign w_addend  = r_rb[r_cnt] ? r_ra : '0;

    m31_addm u_addm (
        .i_x   (w_acc_dbl),
        .i_y   (w_addend),
        .o_sum (w_acc_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ra  <= '0;
            r_rb  <= '0;
            r_acc <= '0;
            r_cnt <= '0;
            _mul  <= '0;
            _done <= 1'b0;
        end else begin
            _done <= w_last;
            if (w_start) begin
                r_ra  <= canon(a);
                r_rb  <= canon(b);
                r_acc <= '0;
                r_cnt <= 5'(NB - 1);
            end else if (r_state == RUN) begin
                r_acc <= w_acc_nxt;
                r_cnt <= r_cnt - 5'd1;
                if (w_last) begin
                    _mul <= w_acc_nxt;
                end
            end
        end
    end

    assign _rdy = (r_state == IDLE);

endmodule

// File: tb/tb_mod_mul_m31.sv
// Directed bench for mod_mul_m31: hand-computed products, handshake corner
// cases, mid-run reset, back-to-back ops and a div/mul round-trip chain.
module tb_mod_mul_m31;

    localparam logic [30:0] P = 31'h7FFFFFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        opselect = 1'b0;
    logic [30:0] a = '0;
    logic [30:0] b = '0;
    logic [30:0] _mul;
    logic        _rdy;
    logic        _done;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    mod_mul_m31 #(.NB(31)) dut (
        .clk      (clk),
        .rst      (rst),
        .opselect (opselect),
        .a        (a),
        .b        (b),
        ._mul     (_mul),
        ._rdy     (_rdy),
        ._done    (_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [30:0] mulmod(input logic [30:0] x, input logic [30:0] y);
        logic [63:0] prod;
        prod = ({33'd0, x} * {33'd0, y}) % {33'd0, P};
        return prod[30:0];
    endfunction

    function automatic logic [30:0] inv(input logic [30:0] x);
        logic [30:0] r;
        logic [30:0] base;
        logic [30:0] e;
        r    = 31'd1;
        base = x;
        e    = P - 31'd2;
        for (int i = 0; i < 31; i++) begin
            if (e[i]) r = mulmod(r, base);
            base = mulmod(base, base);
        end
        return r;
    endfunction

    task automatic do_op(input string tag, input logic [30:0] ta, input logic [30:0] tb_, input logic [30:0] exp);
        int unsigned n;
        logic        seen;
        @(posedge clk); #1;
        a = ta; b = tb_; opselect = 1'b1;
        @(posedge clk); #1;
        opselect = 1'b0;
        check({tag, "_busy"}, {31'd0, _rdy}, 32'd0);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(posedge clk); #1;
            n++;
            seen = _done;
        end
        check({tag, "_lat"}, n, 32'd31);
        check({tag, "_mul"}, {1'b0, _mul}, {1'b0, exp});
        check({tag, "_rdy"}, {31'd0, _rdy}, 32'd1);
    endtask

    initial begin
        int unsigned doneat;
        int unsigned t1;
        int unsigned t2;
        int unsigned ndone;
        logic [30:0] ra, rb, q;

        repeat (2) @(posedge clk);
        #1;
        check("rst_mul", {1'b0, _mul}, 32'd0);
        check("rst_rdy", {31'd0, _rdy}, 32'd1);
        check("rst_done", {31'd0, _done}, 32'd0);
        rst = 1'b0;

        do_op("t3x5",     31'd3,          31'd5,          31'd15);
        do_op("pm1sq",    31'h7FFFFFFE,   31'h7FFFFFFE,   31'd1);
        do_op("pow31",    31'h40000000,   31'd2,          31'd1);
        do_op("a_is_p",   31'h7FFFFFFF,   31'd7,          31'd0);
        do_op("zero_a",   31'd0,          31'h7FFFFFFE,   31'd0);
        do_op("p_p",      31'h7FFFFFFF,   31'h7FFFFFFF,   31'd0);
        do_op("mid",      31'd123456,     31'd789,        31'd97406784);
        do_op("sq65536",  31'd65536,      31'd65536,      31'd2);
        do_op("neg5",     31'h7FFFFFFE,   31'd5,          31'h7FFFFFFA);
        do_op("pow60",    31'h40000000,   31'h40000000,   31'h20000000);
        do_op("third",    31'd3,          31'h2AAAAAAA,   31'h7FFFFFFE);
        do_op("one",      31'd1,          31'h7FFFFFFE,   31'h7FFFFFFE);

        // Extra opselect pulses and operand churn during a run, including the completion edge.
        @(posedge clk); #1;
        a = 31'd3; b = 31'd5; opselect = 1'b1;
        @(posedge clk); #1;
        opselect = 1'b0;
        doneat = 0;
        for (int n = 1; n <= 31; n++) begin
            @(posedge clk); #1;
            if (_done) doneat = n;
            if (n == 4)  begin opselect = 1'b1; a = 31'd7; b = 31'd9; end
            if (n == 5)  begin opselect = 1'b0; a = 31'd100; b = 31'd200; end
            if (n == 29) opselect = 1'b1;
            if (n == 31) opselect = 1'b0;
        end
        check("ign_lat", doneat, 32'd31);
        check("ign_mul", {1'b0, _mul}, 32'd15);
        @(posedge clk); #1;
        check("ign_norestart", {31'd0, _rdy}, 32'd1);
        check("ign_done_clr", {31'd0, _done}, 32'd0);

        // Reset at cycle 10 of a run aborts it.
        @(posedge clk); #1;
        a = 31'h7FFFFFFE; b = 31'h7FFFFFFE; opselect = 1'b1;
        @(posedge clk); #1;
        opselect = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_mul", {1'b0, _mul}, 32'd0);
        check("abort_rdy", {31'd0, _rdy}, 32'd1);
        ndone = 0;
        for (int n = 0; n < 40; n++) begin
            if (_done) ndone++;
            @(posedge clk); #1;
        end
        check("abort_nodone", ndone, 32'd0);
        do_op("after_abort", 31'd11, 31'd13, 31'd143);

        // opselect held high: one op every 32 cycles.
        @(posedge clk); #1;
        a = 31'd6; b = 31'd7; opselect = 1'b1;
        t1 = 0; t2 = 0;
        for (int n = 1; n <= 100 && t2 == 0; n++) begin
            @(posedge clk); #1;
            if (_done) begin
                if (t1 == 0) t1 = n;
                else         t2 = n;
            end
        end
        opselect = 1'b0;
        check("b2b_period", t2 - t1, 32'd32);
        check("b2b_mul", {1'b0, _mul}, 32'd42);
        repeat (40) @(posedge clk);

        // Round trip: q = x / y, then q * y must give x back.
        for (int i = 0; i < 4; i++) begin
            ra = 31'($urandom_range(32'h7FFFFFFE, 0));
            rb = 31'($urandom_range(32'h7FFFFFFE, 1));
            q  = mulmod(ra, inv(rb));
            do_op("chain", q, rb, ra);
        end

        for (int i = 0; i < 12; i++) begin
            ra = 31'($urandom_range(32'h7FFFFFFF, 0));
            rb = 31'($urandom_range(32'h7FFFFFFF, 0));
            do_op("rand", ra, rb, mulmod(ra, rb));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
